muldiv_sequencer: RTL and testbench

- Iterative signed multiply/divide engine with its own control FSM. It replaces the free-running multiplier and divisor instances in the multicycle CPU.
- Accepts one-cycle start pulses from the main control unit and holds the control unit stalled through `busy`/`stall`.
- Produces the Hi/Lo results plus a one-cycle write strobe, and flags divide-by-zero for the exception path.
- Sits between the ALU A/B operand muxes and the Hi/Lo registers.

---
 rtl/muldiv_sequencer.sv | 169 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide engine with its own control FSM.
// Radix-2 Booth multiply and restoring divide, one step per cycle.
// Ports: clock, reset (async, active-low); start_mult/start_div pulses,
//   abort cancel; operand_a/operand_b sampled on start only.
//   busy (registered), stall (busy|starts), done/hilo_load strobe,
//   divby0 strobe; hi/lo result registers (upper/rem, lower/quot).
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             abort,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             hilo_load,
    output logic             divby0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE, MULT, DIV, SIGN, DONE, DZ
    } stateT;

    stateT state, stateNext;

    // Layout for both ops: [2W:W+1] upper/remainder,
    // [W:1] lower/quotient, [0] Booth history bit.
    logic [2*WIDTH:0] acc, accNext;
    logic [WIDTH-1:0] mcand, mcandNext;
    logic [CW-1:0]    counter, counterNext;
    logic             signA, signANext;
    logic             signB, signBNext;

    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   boothUpper, mcandExt, boothSum;
    logic [WIDTH-1:0] remNow, quoNow;
    logic [WIDTH:0]   divShifted, divDiff;
    logic [WIDTH-1:0] remSigned, quoSigned;
    logic             lastStep;

    assign absA = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign absB = operand_b[WIDTH-1] ? -operand_b : operand_b;

    // Upper half is sign-extended by one bit so subtracting the most
    // negative multiplicand cannot overflow before the shift.
    assign boothUpper = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    assign mcandExt   = {mcand[WIDTH-1], mcand};
    always_comb begin
        boothSum = boothUpper;
        if (acc[1:0] == 2'b01) begin
            boothSum = boothUpper + mcandExt;
        end else if (acc[1:0] == 2'b10) begin
            boothSum = boothUpper - mcandExt;
        end
    end

    assign remNow     = acc[2*WIDTH:WIDTH+1];
    assign quoNow     = acc[WIDTH:1];
    assign divShifted = {remNow, quoNow[WIDTH-1]};
    assign divDiff    = divShifted - {1'b0, mcand};

    assign remSigned = signA ? -remNow : remNow;
    assign quoSigned = (signA ^ signB) ? -quoNow : quoNow;

    assign lastStep = (counter == CW'(WIDTH - 1));

    always_comb begin
        stateNext   = state;
        accNext     = acc;
        mcandNext   = mcand;
        counterNext = counter;
        signANext   = signA;
        signBNext   = signB;
        unique case (state)
            IDLE: begin
                if (!abort) begin
                    if (start_div) begin
                        if (operand_b == '0) begin
                            stateNext = DZ;
                        end else begin
                            signANext   = operand_a[WIDTH-1];
                            signBNext   = operand_b[WIDTH-1];
                            mcandNext   = absB;
                            accNext     = {{WIDTH{1'b0}}, absA, 1'b0};
                            counterNext = '0;
                            stateNext   = DIV;
                        end
                    end else if (start_mult) begin
                        mcandNext   = operand_a;
                        accNext     = {{WIDTH{1'b0}}, operand_b, 1'b0};
                        counterNext = '0;
                        stateNext   = MULT;
                    end
                end
            end
            MULT: begin
                accNext     = {boothSum, acc[WIDTH:1]};
                counterNext = counter + CW'(1);
                if (lastStep) begin
                    stateNext = DONE;
                end
            end
            DIV: begin
                if (!divDiff[WIDTH]) begin
                    accNext = {divDiff[WIDTH-1:0],
                               quoNow[WIDTH-2:0], 1'b1, 1'b0};
                end else begin
                    accNext = {divShifted[WIDTH-1:0],
                               quoNow[WIDTH-2:0], 1'b0, 1'b0};
                end
                counterNext = counter + CW'(1);
                if (lastStep) begin
                    stateNext = SIGN;
                end
            end
            SIGN: begin
                accNext   = {remSigned, quoSigned, 1'b0};
                stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            DZ:      stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (abort && state != IDLE) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            counter <= '0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= stateNext;
            acc     <= accNext;
            mcand   <= mcandNext;
            counter <= counterNext;
            signA   <= signANext;
            signB   <= signBNext;
            busy    <= (stateNext != IDLE);
            if (done) begin
                hi <= acc[2*WIDTH:WIDTH+1];
                lo <= acc[WIDTH:1];
            end
        end
    end

    // An abort in the DONE cycle must suppress the write as well.
    assign done      = (state == DONE) && !abort;
    assign hilo_load = done;
    assign divby0    = (state == DZ) && !abort;
    assign stall     = busy | start_mult | start_div;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, scoreboard
// of expected strobes/results, plus abort/reset/busy sequences.
module tb_muldiv_sequencer;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic        abort;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        stall;
    logic        done;
    logic        hilo_load;
    logic        divby0;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start_mult(start_mult),
        .start_div (start_div),
        .abort     (abort),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hilo_load (hilo_load),
        .divby0    (divby0),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } expT;

    typedef struct {
        logic        isDiv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vecT;

    expT  sbq[$];
    expT  cur;
    bit   pending;
    int   cyc;
    int   passCnt;
    int   totalCnt;
    logic [31:0] lastHi;
    logic [31:0] lastLo;
    vecT  vecs[8];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model(input logic isDiv,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] h,
                                  output logic [31:0] l);
        longint sa, sb, r, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!isDiv) begin
            r = sa * sb;
            h = r[63:32];
            l = r[31:0];
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    // Monitor: pop on each strobe, check hi/lo one cycle later
    // (after the Hi/Lo load edge).
    initial begin
        pending = 0;
        forever begin
            @(negedge clock);
            if (pending) begin
                check("hi", hi, cur.hi);
                check("lo", lo, cur.lo);
                pending = 0;
            end
            if (done || divby0) begin
                if (sbq.size() == 0) begin
                    check("spurious strobe", {30'b0, done, divby0}, 32'd0);
                end else begin
                    cur = sbq.pop_front();
                    check("strobe cycle", cyc, cur.cyc);
                    check("divby0", {31'b0, divby0}, {31'b0, cur.dz});
                    check("done", {31'b0, done}, {31'b0, !cur.dz});
                    check("hilo_load", {31'b0, hilo_load},
                          {31'b0, !cur.dz});
                    pending = 1;
                end
            end
        end
    end

    task automatic runOp(input logic isDiv, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi,
                         input logic [31:0] expLo, input bit both,
                         input int pokeAt);
        expT e;
        bit  isDz;
        int  lat;
        int  n;
        int  c;
        isDz  = isDiv && (b == 32'd0);
        lat   = isDz ? 1 : (isDiv ? 34 : 33);
        e.hi  = isDz ? lastHi : expHi;
        e.lo  = isDz ? lastLo : expLo;
        e.dz  = isDz;
        e.cyc = cyc + lat;
        sbq.push_back(e);
        start_div  = isDiv;
        start_mult = !isDiv || both;
        operand_a  = a;
        operand_b  = b;
        #1;
        check("stall on start", {31'b0, stall}, 32'd1);
        tick();
        start_div  = 1'b0;
        start_mult = 1'b0;
        n = 0;
        c = 1;
        while (busy && n < 60) begin
            start_mult = (c == pokeAt);
            operand_a  = $urandom;
            operand_b  = $urandom;
            tick();
            n++;
            c++;
        end
        start_mult = 1'b0;
        check("busy cycles", n, lat);
        tick();
        if (!isDz) begin
            lastHi = expHi;
            lastLo = expLo;
        end
    endtask

    initial begin
        logic [31:0] a, b, eh, el;
        bit isDiv;
        int n;
        passCnt    = 0;
        totalCnt   = 0;
        lastHi     = 32'd0;
        lastLo     = 32'd0;
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        abort      = 1'b0;
        operand_a  = 32'd0;
        operand_b  = 32'd0;

        vecs[0] = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{1'b1, 32'd1234, 32'd0, 32'd0, 32'd0};
        vecs[2] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
        vecs[4] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
        vecs[5] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14};
        vecs[6] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
        vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1};

        tick();
        tick();
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset divby0", {31'b0, divby0}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i].isDiv, vecs[i].a, vecs[i].b,
                  vecs[i].expHi, vecs[i].expLo, 1'b0, 0);
        end

        for (int i = 0; i < 6; i++) begin
            isDiv = i[0];
            a = $urandom;
            b = isDiv ? ($urandom & 32'h8000FFFF) | 32'd1 : $urandom;
            model(isDiv, a, b, eh, el);
            runOp(isDiv, a, b, eh, el, 1'b0, 0);
        end

        // Start while busy is ignored.
        model(1'b1, 32'd1000, 32'hFFFFFFF3, eh, el);
        runOp(1'b1, 32'd1000, 32'hFFFFFFF3, eh, el, 1'b0, 5);

        // Simultaneous starts: divide wins.
        model(1'b1, 32'hFFFFFF9C, 32'd9, eh, el);
        runOp(1'b1, 32'hFFFFFF9C, 32'd9, eh, el, 1'b1, 0);

        // Abort at cycle 10 of a multiply.
        start_mult = 1'b1;
        operand_a  = 32'd5;
        operand_b  = 32'd6;
        tick();
        start_mult = 1'b0;
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", {31'b0, busy}, 32'd0);
        repeat (40) tick();
        check("abort hi", hi, lastHi);
        check("abort lo", lo, lastLo);

        // Abort in the DONE cycle suppresses the write.
        start_mult = 1'b1;
        operand_a  = 32'd9;
        operand_b  = 32'd9;
        tick();
        start_mult = 1'b0;
        repeat (32) tick();
        abort = 1'b1;
        #1;
        check("abort-in-done busy", {31'b0, busy}, 32'd1);
        check("abort-in-done done", {31'b0, done}, 32'd0);
        tick();
        abort = 1'b0;
        check("abort-in-done idle", {31'b0, busy}, 32'd0);
        tick();
        check("abort-in-done hi", hi, lastHi);
        check("abort-in-done lo", lo, lastLo);

        // Abort in IDLE blocks a same-cycle start.
        abort      = 1'b1;
        start_mult = 1'b1;
        tick();
        abort      = 1'b0;
        start_mult = 1'b0;
        check("idle abort blocks start", {31'b0, busy}, 32'd0);
        tick();

        // Reset mid-divide.
        sbq.push_back('{32'd0, 32'd0, 1'b0, 0});
        start_div = 1'b1;
        operand_a = 32'd77;
        operand_b = 32'd5;
        tick();
        start_div = 1'b0;
        repeat (14) tick();
        #2;
        reset = 1'b0;
        #1;
        check("async reset busy", {31'b0, busy}, 32'd0);
        check("async reset hi", hi, 32'd0);
        check("async reset lo", lo, 32'd0);
        sbq.delete();
        lastHi = 32'd0;
        lastLo = 32'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post reset busy", {31'b0, busy}, 32'd0);
        runOp(1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

        n = sbq.size();
        check("scoreboard drained", n, 32'd0);
        tick();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
